// File: rtl/rf_pkg.sv
// Shared types for the register-file write-back queue.
package rf_pkg;

    localparam int RF_N    = 32;
    localparam int RF_ADDR = 5;

    typedef struct packed {
        logic [RF_ADDR-1:0] addr;
        logic [RF_N-1:0]    data;
    } wb_entry_t;

endpackage

// File: rtl/rf_writeback_queue_if.sv
// Producer/consumer bundle of the write-back queue; forwarding signals exist only
// when RF_WB_FWD_EN is defined.
interface rf_writeback_queue_if #(
    parameter int N     = 32,
    parameter int ADDR  = 5,
    parameter int DEPTH = 4
) ();

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic            alu_valid_i;
    logic            alu_ready_o;
    logic [ADDR-1:0] alu_addr_i;
    logic [N-1:0]    alu_data_i;
    logic            mem_valid_i;
    logic            mem_ready_o;
    logic [ADDR-1:0] mem_addr_i;
    logic [N-1:0]    mem_data_i;
    logic            wr_en_o;
    logic [ADDR-1:0] wr_addr_o;
    logic [N-1:0]    wr_data_o;
    logic [CNT_W-1:0] pending_o;
`ifdef RF_WB_FWD_EN
    logic [ADDR-1:0] fwd_addr_i;
    logic            fwd_hit_o;
    logic [N-1:0]    fwd_data_o;

    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        output mem_valid_i, mem_addr_i, mem_data_i,
        output fwd_addr_i,
        input  alu_ready_o, mem_ready_o,
        input  wr_en_o, wr_addr_o, wr_data_o, pending_o,
        input  fwd_hit_o, fwd_data_o
    );

    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        input  mem_valid_i, mem_addr_i, mem_data_i,
        input  fwd_addr_i,
        output alu_ready_o, mem_ready_o,
        output wr_en_o, wr_addr_o, wr_data_o, pending_o,
        output fwd_hit_o, fwd_data_o
    );
`else
    modport master (
        output alu_valid_i, alu_addr_i, alu_data_i,
        output mem_valid_i, mem_addr_i, mem_data_i,
        input  alu_ready_o, mem_ready_o,
        input  wr_en_o, wr_addr_o, wr_data_o, pending_o
    );

    modport slave (
        input  alu_valid_i, alu_addr_i, alu_data_i,
        input  mem_valid_i, mem_addr_i, mem_data_i,
        output alu_ready_o, mem_ready_o,
        output wr_en_o, wr_addr_o, wr_data_o, pending_o
    );
`endif

endinterface

// File: rtl/rf_wb_fifo.sv
// Two-push / one-pop FIFO of write-back entries. With RF_WB_FWD_EN defined it also
// exposes the read pointer and raw storage for the forwarding search.
module rf_wb_fifo
    import rf_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push0_i,
    input  wb_entry_t        push0_entry_i,
    input  logic             push1_i,
    input  wb_entry_t        push1_entry_i,
    input  logic             pop_i,
    output logic [CNT_W-1:0] count_o,
    output wb_entry_t        head_o
`ifdef RF_WB_FWD_EN
    ,
    output logic [PTR_W-1:0] rd_ptr_o,
    output wb_entry_t        entries_o [DEPTH]
`endif
);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] push1_slot;
    wb_entry_t        mem_q [DEPTH];

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        push1_slot = push0_i ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        wr_ptr_d   = wr_ptr_q + PTR_W'(push0_i) + PTR_W'(push1_i);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop_i);
        count_d    = count_q + CNT_W'(push0_i) + CNT_W'(push1_i) - CNT_W'(pop_i);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; count and pointers alone define which slots are live.
    always_ff @(posedge clk) begin
        if (push0_i) mem_q[wr_ptr_q]   <= push0_entry_i;
        if (push1_i) mem_q[push1_slot] <= push1_entry_i;
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

`ifdef RF_WB_FWD_EN
    assign rd_ptr_o  = rd_ptr_q;
    assign entries_o = mem_q;
`endif

endmodule

// File: rtl/rf_writeback_queue.sv
// Write-back queue merging ALU and load results ahead of the register file write port.
// Define RF_WB_FWD_EN to add the combinational forwarding search (fwd_* signals).
module rf_writeback_queue
    import rf_pkg::*;
#(
    parameter int N     = RF_N,
    parameter int ADDR  = RF_ADDR,
    parameter int DEPTH = 4
) (
    input logic                 clk,
    input logic                 reset,
    rf_writeback_queue_if.slave bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] space;
    logic             mem_ready;
    logic             alu_ready;
    logic             mem_push;
    logic             alu_push;
    logic             pop;
    wb_entry_t        head;
    wb_entry_t        mem_entry;
    wb_entry_t        alu_entry;

    logic             wr_en_q, wr_en_d;
    logic [ADDR-1:0]  wr_addr_q, wr_addr_d;
    logic [N-1:0]     wr_data_q, wr_data_d;

    // Readiness ignores the pop happening in the same cycle, so a full queue stalls
    // both producers even though one slot is about to free up.
    always_comb begin
        space     = CNT_W'(DEPTH) - count;
        mem_ready = reset && (space >= CNT_W'(1));
        alu_ready = reset && ((space >= CNT_W'(2)) ||
                              ((space == CNT_W'(1)) && !bus.mem_valid_i));
    end

    // R0 is hardwired zero: the handshake completes but the entry is dropped.
    assign mem_push  = bus.mem_valid_i && mem_ready && (bus.mem_addr_i != '0);
    assign alu_push  = bus.alu_valid_i && alu_ready && (bus.alu_addr_i != '0);
    assign pop       = (count != '0);
    assign mem_entry = '{addr: bus.mem_addr_i, data: bus.mem_data_i};
    assign alu_entry = '{addr: bus.alu_addr_i, data: bus.alu_data_i};

`ifdef RF_WB_FWD_EN
    logic [PTR_W-1:0] rd_ptr;
    wb_entry_t        entries [DEPTH];
`endif

    rf_wb_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk          (clk),
        .reset        (reset),
        .push0_i      (mem_push),
        .push0_entry_i(mem_entry),
        .push1_i      (alu_push),
        .push1_entry_i(alu_entry),
        .pop_i        (pop),
        .count_o      (count),
        .head_o       (head)
`ifdef RF_WB_FWD_EN
        ,
        .rd_ptr_o     (rd_ptr),
        .entries_o    (entries)
`endif
    );

    always_comb begin
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        if (pop) begin
            wr_en_d   = 1'b1;
            wr_addr_d = head.addr;
            wr_data_d = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.mem_ready_o = mem_ready;
    assign bus.alu_ready_o = alu_ready;
    assign bus.wr_en_o     = wr_en_q;
    assign bus.wr_addr_o   = wr_addr_q;
    assign bus.wr_data_o   = wr_data_q;
    assign bus.pending_o   = count;

`ifdef RF_WB_FWD_EN
    logic             fwd_hit;
    logic [N-1:0]     fwd_data;
    logic [PTR_W-1:0] idx;

    // Scan oldest to newest so the last match overwrites earlier ones; the
    // output stage register is older than anything still in the queue.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        if (bus.fwd_addr_i != '0) begin
            if (wr_en_q && (wr_addr_q == bus.fwd_addr_i)) begin
                fwd_hit  = 1'b1;
                fwd_data = wr_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = rd_ptr + PTR_W'(i);
                if ((CNT_W'(i) < count) && (entries[idx].addr == bus.fwd_addr_i)) begin
                    fwd_hit  = 1'b1;
                    fwd_data = entries[idx].data;
                end
            end
        end
    end

    assign bus.fwd_hit_o  = fwd_hit;
    assign bus.fwd_data_o = fwd_data;
`endif

endmodule
